// File: rtl/data_mem_responder.sv
// Load/store responder for a word-organised data RAM with RV32 byte/half/word sizing and wait states.
// Optional access-fault reporting is compiled in with the DMEM_ERR_EN macro.
module data_mem_responder #(
  parameter int DEPTH       = 256,
  parameter int ADDR_W      = 12,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [3:0] WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t            r_state;
  logic              r_reqReady;
  logic              r_rspValid;
  logic [31:0]       r_rspRdata;
  logic              r_rspErr;
  logic [3:0]        r_waitCnt;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [2:0]        r_funct3;
  logic [31:0]       r_wdata;
  logic [31:0]       r_mem [DEPTH];

  logic              w_accept;
  logic              w_commit;
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [2:0]        w_funct3;
  logic [31:0]       w_wdata;
  logic [IDX_W-1:0]  w_idx;
  logic [1:0]        w_lane;
  logic [31:0]       w_word;
  logic [1:0]        w_size;
  logic              w_signed;
  logic              w_err;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_loadData;
  logic [31:0]       w_newWord;
  logic              w_unused;

  // With zero wait states the access commits on the accepting edge, so the live request is used.
  assign w_accept = (r_state == ST_IDLE) && req_valid && r_reqReady;
  assign w_commit = (w_accept && (WAIT_STATES == 0)) ||
                    ((r_state == ST_WAIT) && (r_waitCnt == 4'd0));
  assign w_we     = (r_state == ST_IDLE) ? req_we     : r_we;
  assign w_addr   = (r_state == ST_IDLE) ? req_addr   : r_addr;
  assign w_funct3 = (r_state == ST_IDLE) ? req_funct3 : r_funct3;
  assign w_wdata  = (r_state == ST_IDLE) ? req_wdata  : r_wdata;
  assign w_idx    = w_addr[IDX_W+1:2];
  assign w_lane   = w_addr[1:0];
  assign w_word   = r_mem[w_idx];
  assign w_unused = ^w_addr[ADDR_W-1:IDX_W+2];

  always_comb begin
    w_size   = 2'd2;
    w_signed = 1'b0;
    case (w_funct3)
      3'b000: begin w_size = 2'd0; w_signed = 1'b1; end
      3'b001: begin w_size = 2'd1; w_signed = 1'b1; end
      3'b100: if (!w_we) w_size = 2'd0;
      3'b101: if (!w_we) w_size = 2'd1;
      default: w_size = 2'd2;
    endcase
  end

  always_comb begin
    w_err = 1'b0;
`ifdef DMEM_ERR_EN
    if (w_we)
      w_err = !(w_funct3 == 3'b000 || w_funct3 == 3'b001 || w_funct3 == 3'b010);
    else
      w_err = (w_funct3 == 3'b011 || w_funct3 == 3'b110 || w_funct3 == 3'b111);
    if (w_size == 2'd1 && w_addr[0])
      w_err = 1'b1;
    if (w_size == 2'd2 && w_addr[1:0] != 2'b00)
      w_err = 1'b1;
`endif
  end

  always_comb begin
    w_byte     = w_word[{w_lane, 3'b000} +: 8];
    w_half     = w_addr[1] ? w_word[31:16] : w_word[15:0];
    w_loadData = w_word;
    if (w_size == 2'd0)
      w_loadData = w_signed ? {{24{w_byte[7]}}, w_byte} : {24'd0, w_byte};
    else if (w_size == 2'd1)
      w_loadData = w_signed ? {{16{w_half[15]}}, w_half} : {16'd0, w_half};
  end

  always_comb begin
    w_newWord = w_word;
    if (w_size == 2'd0)
      w_newWord[{w_lane, 3'b000} +: 8] = w_wdata[7:0];
    else if (w_size == 2'd1)
      w_newWord[{w_addr[1], 4'b0000} +: 16] = w_wdata[15:0];
    else
      w_newWord = w_wdata;
  end

  // Storage is never cleared; a reset on the commit edge suppresses the write.
  always_ff @(posedge clk) begin
    if (!Reset && w_commit && w_we && !w_err)
      r_mem[w_idx] <= w_newWord;
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      r_state    <= ST_IDLE;
      r_reqReady <= 1'b1;
      r_rspValid <= 1'b0;
      r_rspRdata <= 32'd0;
      r_rspErr   <= 1'b0;
      r_waitCnt  <= 4'd0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_funct3   <= 3'd0;
      r_wdata    <= 32'd0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_accept) begin
          r_we       <= req_we;
          r_addr     <= req_addr;
          r_funct3   <= req_funct3;
          r_wdata    <= req_wdata;
          r_reqReady <= 1'b0;
          r_waitCnt  <= WAIT_INIT;
          r_state    <= (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
        end
        ST_WAIT: if (r_waitCnt == 4'd0) r_state <= ST_RESP;
                 else r_waitCnt <= r_waitCnt - 4'd1;
        ST_RESP: if (rsp_ready) begin
          r_state    <= ST_IDLE;
          r_reqReady <= 1'b1;
          r_rspValid <= 1'b0;
          r_rspRdata <= 32'd0;
          r_rspErr   <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
      if (w_commit) begin
        r_rspValid <= 1'b1;
        r_rspRdata <= (w_we || w_err) ? 32'd0 : w_loadData;
        r_rspErr   <= w_err;
      end
    end
  end

  assign req_ready = r_reqReady;
  assign rsp_valid = r_rspValid;
  assign rsp_rdata = r_rspRdata;
  assign rsp_err   = r_rspErr;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: one instance with no wait states, one with three.
// Expectations for fault cases follow the DMEM_ERR_EN macro.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        Reset;
  logic        sel;
  logic        reqValid;
  logic        reqWe;
  logic [11:0] reqAddr;
  logic [2:0]  reqFunct3;
  logic [31:0] reqWdata;
  logic        rspReady;

  logic        reqReady0, rspValid0, rspErr0;
  logic [31:0] rspRdata0;
  logic        reqReady3, rspValid3, rspErr3;
  logic [31:0] rspRdata3;

  logic        reqReadyM, rspValidM, rspErrM;
  logic [31:0] rspRdataM;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t sbQ[$];

  always #5 clk = ~clk;

  assign reqReadyM = sel ? reqReady3 : reqReady0;
  assign rspValidM = sel ? rspValid3 : rspValid0;
  assign rspErrM   = sel ? rspErr3   : rspErr0;
  assign rspRdataM = sel ? rspRdata3 : rspRdata0;

  data_mem_responder #(.DEPTH(256), .ADDR_W(12), .WAIT_STATES(0)) dut0 (
    .clk(clk), .Reset(Reset),
    .req_valid(reqValid && !sel), .req_ready(reqReady0),
    .req_we(reqWe), .req_addr(reqAddr), .req_funct3(reqFunct3), .req_wdata(reqWdata),
    .rsp_valid(rspValid0), .rsp_ready(rspReady && !sel),
    .rsp_rdata(rspRdata0), .rsp_err(rspErr0)
  );

  data_mem_responder #(.DEPTH(256), .ADDR_W(12), .WAIT_STATES(3)) dut3 (
    .clk(clk), .Reset(Reset),
    .req_valid(reqValid && sel), .req_ready(reqReady3),
    .req_we(reqWe), .req_addr(reqAddr), .req_funct3(reqFunct3), .req_wdata(reqWdata),
    .rsp_valid(rspValid3), .rsp_ready(rspReady && sel),
    .rsp_rdata(rspRdata3), .rsp_err(rspErr3)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h want 0x%08h", tag, observed, expected);
    end
  endtask

  // One full transaction: push expectation, wait for accept, measure latency, optionally stall, pop and compare.
  task automatic applyStimulus(input logic we, input logic [11:0] addr, input logic [2:0] funct3,
                               input logic [31:0] wdata, input logic [31:0] expRdata,
                               input logic expErr, input int hold, input int ws);
    exp_t        e;
    int          cyc;
    logic [31:0] heldData;
    logic        heldErr;
    e.rdata = expRdata;
    e.err   = expErr;
    sbQ.push_back(e);
    @(negedge clk);
    reqWe = we; reqAddr = addr; reqFunct3 = funct3; reqWdata = wdata; reqValid = 1'b1;
    cyc = 0;
    while (!reqReadyM && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 50) begin
      checkOutput("acceptTimeout", 32'd0, 32'd1);
      reqValid = 1'b0;
      void'(sbQ.pop_front());
      return;
    end
    @(posedge clk);
    cyc = 0;
    do begin
      @(negedge clk);
      reqValid = 1'b0;
      cyc++;
    end while (!rspValidM && cyc < 50);
    checkOutput("latency", cyc, ws + 1);
    if (!rspValidM) begin
      void'(sbQ.pop_front());
      return;
    end
    heldData = rspRdataM;
    heldErr  = rspErrM;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checkOutput("stallValid", {31'd0, rspValidM}, 32'd1);
      checkOutput("stallData", rspRdataM, heldData);
      checkOutput("stallErr", {31'd0, rspErrM}, {31'd0, heldErr});
      checkOutput("stallReqReady", {31'd0, reqReadyM}, 32'd0);
    end
    e = sbQ.pop_front();
    checkOutput("rdata", rspRdataM, e.rdata);
    checkOutput("err", {31'd0, rspErrM}, {31'd0, e.err});
    rspReady = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rspReady = 1'b0;
    checkOutput("validDrop", {31'd0, rspValidM}, 32'd0);
    checkOutput("readyBack", {31'd0, reqReadyM}, 32'd1);
  endtask

  task automatic runSequence(input int ws);
    applyStimulus(1'b1, 12'h010, 3'b010, 32'hDEADBEEF, 32'h0, 1'b0, 0, ws);
    applyStimulus(1'b0, 12'h010, 3'b010, 32'h0, 32'hDEADBEEF, 1'b0, 0, ws);
    applyStimulus(1'b1, 12'h013, 3'b000, 32'h00000080, 32'h0, 1'b0, 0, ws);
    applyStimulus(1'b0, 12'h013, 3'b000, 32'h0, 32'hFFFFFF80, 1'b0, 0, ws);
    applyStimulus(1'b0, 12'h013, 3'b100, 32'h0, 32'h00000080, 1'b0, 0, ws);
    applyStimulus(1'b0, 12'h010, 3'b010, 32'h0, 32'h80ADBEEF, 1'b0, 5, ws);
    applyStimulus(1'b0, 12'h012, 3'b001, 32'h0, 32'hFFFF80AD, 1'b0, 0, ws);
    applyStimulus(1'b0, 12'h012, 3'b101, 32'h0, 32'h000080AD, 1'b0, 0, ws);
`ifdef DMEM_ERR_EN
    applyStimulus(1'b0, 12'h012, 3'b010, 32'h0, 32'h0, 1'b1, 0, ws);
    applyStimulus(1'b1, 12'h011, 3'b010, 32'h12345678, 32'h0, 1'b1, 0, ws);
    applyStimulus(1'b0, 12'h010, 3'b010, 32'h0, 32'h80ADBEEF, 1'b0, 0, ws);
    applyStimulus(1'b0, 12'h010, 3'b011, 32'h0, 32'h0, 1'b1, 0, ws);
`else
    applyStimulus(1'b0, 12'h012, 3'b010, 32'h0, 32'h80ADBEEF, 1'b0, 0, ws);
    applyStimulus(1'b1, 12'h011, 3'b010, 32'h12345678, 32'h0, 1'b0, 0, ws);
    applyStimulus(1'b0, 12'h010, 3'b010, 32'h0, 32'h12345678, 1'b0, 0, ws);
    applyStimulus(1'b0, 12'h010, 3'b011, 32'h0, 32'h12345678, 1'b0, 0, ws);
`endif
    applyStimulus(1'b1, 12'h400, 3'b010, 32'h0000A5A5, 32'h0, 1'b0, 0, ws);
    applyStimulus(1'b0, 12'h000, 3'b010, 32'h0, 32'h0000A5A5, 1'b0, 0, ws);
    applyStimulus(1'b1, 12'h004, 3'b010, 32'h11223344, 32'h0, 1'b0, 0, ws);
    applyStimulus(1'b1, 12'h006, 3'b001, 32'hFFFFBEEF, 32'h0, 1'b0, 0, ws);
    applyStimulus(1'b0, 12'h004, 3'b010, 32'h0, 32'hBEEF3344, 1'b0, 0, ws);
  endtask

  // Store interrupted by reset in its second wait cycle must be dropped and never committed.
  task automatic resetMidWait();
    int cyc;
    applyStimulus(1'b1, 12'h020, 3'b010, 32'h01020304, 32'h0, 1'b0, 0, 3);
    @(negedge clk);
    reqWe = 1'b1; reqAddr = 12'h020; reqFunct3 = 3'b010; reqWdata = 32'hCAFEF00D; reqValid = 1'b1;
    cyc = 0;
    while (!reqReadyM && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("resetAccept", {31'd0, reqReadyM}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    reqValid = 1'b0;
    @(negedge clk);
    Reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    Reset = 1'b0;
    checkOutput("rstRspValid", {31'd0, rspValidM}, 32'd0);
    checkOutput("rstReqReady", {31'd0, reqReadyM}, 32'd1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput("rstDropped", {31'd0, rspValidM}, 32'd0);
    end
    applyStimulus(1'b0, 12'h020, 3'b010, 32'h0, 32'h01020304, 1'b0, 0, 3);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    Reset = 1'b1; sel = 1'b0; reqValid = 1'b0; reqWe = 1'b0;
    reqAddr = 12'h0; reqFunct3 = 3'b0; reqWdata = 32'h0; rspReady = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    Reset = 1'b0;
    checkOutput("reset0ReqReady", {31'd0, reqReady0}, 32'd1);
    checkOutput("reset0RspValid", {31'd0, rspValid0}, 32'd0);
    checkOutput("reset0Rdata", rspRdata0, 32'd0);
    checkOutput("reset0Err", {31'd0, rspErr0}, 32'd0);
    checkOutput("reset3ReqReady", {31'd0, reqReady3}, 32'd1);
    checkOutput("reset3RspValid", {31'd0, rspValid3}, 32'd0);
    sel = 1'b0;
    runSequence(0);
    sel = 1'b1;
    runSequence(3);
    resetMidWait();
    checkOutput("scoreboardEmpty", sbQ.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
